// File: rtl/fomu_led_pkg.sv
// Shared mode encodings and per-channel level selection for the Fomu LED PWM engine.
package fomu_led_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF     = 2'b00;
    localparam mode_t MODE_STEADY  = 2'b01;
    localparam mode_t MODE_BLINK   = 2'b10;
    localparam mode_t MODE_BREATHE = 2'b11;

    typedef enum logic {
        RAMP_UP   = 1'b0,
        RAMP_DOWN = 1'b1
    } ramp_dir_t;

    function automatic logic mode_level(
        input mode_t mode,
        input logic  phase,
        input logic  below_duty,
        input logic  below_cap
    );
        logic lvl;
        lvl = 1'b0;
        case (mode)
            MODE_STEADY:  lvl = below_duty;
            MODE_BLINK:   lvl = phase & below_duty;
            MODE_BREATHE: lvl = below_cap;
            default:      lvl = 1'b0;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/fomu_breathe_ramp.sv
// Shared triangle ramp for breathing channels: a prescaler gates single steps of an
// up/down counter that turns around at both ends without repeating the endpoint.
module fomu_breathe_ramp
    import fomu_led_pkg::*;
#(
    parameter int unsigned PWM_BITS  = 8,
    parameter int unsigned STEP_LOG2 = 14
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PWM_BITS-1:0] ramp
);

    localparam int unsigned PW = (STEP_LOG2 > 0) ? STEP_LOG2 : 1;
    localparam logic [PW-1:0] PRESC_LAST = (STEP_LOG2 > 0) ? '1 : '0;
    localparam logic [PWM_BITS-1:0] RAMP_MAX = '1;
    localparam logic [PWM_BITS-1:0] RAMP_NEAR_MAX = RAMP_MAX - 1'b1;
    localparam logic [PWM_BITS-1:0] RAMP_NEAR_MIN = 1;

    logic [PW-1:0]       presc;
    logic [PW-1:0]       presc_next;
    logic [PWM_BITS-1:0] ramp_next;
    ramp_dir_t           dir;
    ramp_dir_t           dir_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            ramp  <= '0;
            dir   <= RAMP_UP;
        end else begin
            presc <= presc_next;
            ramp  <= ramp_next;
            dir   <= dir_next;
        end
    end

    // Direction flips on the step that lands on an endpoint, so the endpoint is held one step only.
    always_comb begin
        presc_next = presc + 1'b1;
        ramp_next  = ramp;
        dir_next   = dir;
        if (presc == PRESC_LAST) begin
            presc_next = '0;
            unique case (dir)
                RAMP_UP: begin
                    ramp_next = ramp + 1'b1;
                    if (ramp == RAMP_NEAR_MAX) dir_next = RAMP_DOWN;
                end
                RAMP_DOWN: begin
                    ramp_next = ramp - 1'b1;
                    if (ramp == RAMP_NEAR_MIN) dir_next = RAMP_UP;
                end
            endcase
        end
    end

endmodule

// File: rtl/fomu_rgb_pwm.sv
// N-channel LED PWM engine for the SB_RGBA_DRV RGBnPWM inputs, with a shadowed
// configuration that is promoted to the active set only at a PWM period boundary.
module fomu_rgb_pwm
    import fomu_led_pkg::*;
#(
    parameter int unsigned CHANNELS          = 3,
    parameter int unsigned PWM_BITS          = 8,
    parameter int unsigned LOG2DELAY         = 21,
    parameter int unsigned BREATHE_STEP_LOG2 = 14
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [2*CHANNELS-1:0]        cfg_mode,
    input  logic [PWM_BITS*CHANNELS-1:0] cfg_duty,
    output logic [CHANNELS-1:0]          pwm_out,
    output logic                         period_tick
);

    logic [PWM_BITS-1:0]          pwm_cnt;
    logic [LOG2DELAY:0]           blink_cnt;
    logic                         phase;
    logic [PWM_BITS-1:0]          ramp;
    logic [2*CHANNELS-1:0]        shadow_mode;
    logic [PWM_BITS*CHANNELS-1:0] shadow_duty;
    logic [2*CHANNELS-1:0]        active_mode;
    logic [PWM_BITS*CHANNELS-1:0] active_duty;
    logic                         pending;
    logic [CHANNELS-1:0]          level;

    assign period_tick = (pwm_cnt == '1);
    assign cfg_ready   = ~pending;
    assign phase       = blink_cnt[LOG2DELAY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt   <= '0;
            blink_cnt <= '0;
        end else begin
            pwm_cnt   <= pwm_cnt + 1'b1;
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    fomu_breathe_ramp #(
        .PWM_BITS  (PWM_BITS),
        .STEP_LOG2 (BREATHE_STEP_LOG2)
    ) u_ramp (
        .clk  (clk),
        .rst  (rst),
        .ramp (ramp)
    );

    // Accept and apply are mutually exclusive through pending, so a request landing
    // in the tick cycle is only captured here and waits for the next wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_mode <= '0;
            shadow_duty <= '0;
            active_mode <= '0;
            active_duty <= '0;
            pending     <= 1'b0;
        end else if (period_tick && pending) begin
            active_mode <= shadow_mode;
            active_duty <= shadow_duty;
            pending     <= 1'b0;
        end else if (cfg_valid && !pending) begin
            shadow_mode <= cfg_mode;
            shadow_duty <= cfg_duty;
            pending     <= 1'b1;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        mode_t               mode;
        logic [PWM_BITS-1:0] duty;
        logic [PWM_BITS-1:0] cap;

        assign mode     = active_mode[2*i +: 2];
        assign duty     = active_duty[PWM_BITS*i +: PWM_BITS];
        assign cap      = (ramp < duty) ? ramp : duty;
        assign level[i] = mode_level(mode, phase, pwm_cnt < duty, pwm_cnt < cap);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out <= '0;
        end else begin
            pwm_out <= level;
        end
    end

endmodule

// File: tb/tb_fomu_rgb_pwm.sv
// Directed bench for fomu_rgb_pwm with a time-based reference model checked every cycle.
module tb_fomu_rgb_pwm;
    import fomu_led_pkg::*;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [5:0]  cfg_mode;
    logic [11:0] cfg_duty;
    logic [2:0]  pwm_out;
    logic        period_tick;

    int tests = 0;
    int fails = 0;
    logic check_en = 1'b0;

    fomu_rgb_pwm #(
        .CHANNELS          (3),
        .PWM_BITS          (4),
        .LOG2DELAY         (5),
        .BREATHE_STEP_LOG2 (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_mode    (cfg_mode),
        .cfg_duty    (cfg_duty),
        .pwm_out     (pwm_out),
        .period_tick (period_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: everything derives from t, the number of clock edges since reset release.
    int unsigned t;
    logic [1:0]  act_mode [3];
    logic [3:0]  act_duty [3];
    logic [1:0]  sh_mode  [3];
    logic [3:0]  sh_duty  [3];
    logic        m_pend;
    logic [2:0]  exp_out;

    function automatic logic model_level(input logic [1:0] mode, input int duty, input int unsigned tt);
        int cnt;
        int ph;
        int k;
        int rmp;
        int cap;
        cnt = int'(tt % 16);
        ph  = int'((tt / 32) % 2);
        k   = int'((tt / 4) % 30);
        rmp = (k <= 15) ? k : 30 - k;
        cap = (rmp < duty) ? rmp : duty;
        case (mode)
            2'b01:   return cnt < duty;
            2'b10:   return (ph == 1) && (cnt < duty);
            2'b11:   return cnt < cap;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t       <= 0;
            m_pend  <= 1'b0;
            exp_out <= '0;
            for (int ch = 0; ch < 3; ch++) begin
                act_mode[ch] <= 2'b00;
                act_duty[ch] <= 4'd0;
                sh_mode[ch]  <= 2'b00;
                sh_duty[ch]  <= 4'd0;
            end
        end else begin
            for (int ch = 0; ch < 3; ch++)
                exp_out[ch] <= model_level(act_mode[ch], int'(act_duty[ch]), t);
            t <= t + 1;
            if ((t % 16) == 15 && m_pend) begin
                for (int ch = 0; ch < 3; ch++) begin
                    act_mode[ch] <= sh_mode[ch];
                    act_duty[ch] <= sh_duty[ch];
                end
                m_pend <= 1'b0;
            end else if (cfg_valid && !m_pend) begin
                for (int ch = 0; ch < 3; ch++) begin
                    sh_mode[ch] <= cfg_mode[2*ch +: 2];
                    sh_duty[ch] <= cfg_duty[4*ch +: 4];
                end
                m_pend <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("pwm_out", {29'd0, pwm_out}, {29'd0, exp_out});
            check("period_tick", {31'd0, period_tick}, {31'd0, ((t % 16) == 15)});
            check("cfg_ready", {31'd0, cfg_ready}, {31'd0, !m_pend});
        end
    end

    task automatic pulse_cfg(input logic [5:0] m, input logic [11:0] d);
        cfg_mode  = m;
        cfg_duty  = d;
        cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cfg_ready) return;
        end
        check("wait_ready_timeout", 0, 1);
    endtask

    task automatic wait_cnt(input int c);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if ((t % 16) == c) return;
        end
        check("wait_cnt_timeout", 0, 1);
    endtask

    task automatic count_high(input int ch, input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (pwm_out[ch]) c++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int mx;
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_mode  = '0;
        cfg_duty  = '0;
        #1 check_en = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_pwm_out", {29'd0, pwm_out}, 0);
        check("reset_cfg_ready", {31'd0, cfg_ready}, 1);
        #2 rst = 1'b0;
        @(negedge clk);

        // ch0 STEADY duty 4
        pulse_cfg(6'b00_00_01, {4'd0, 4'd0, 4'd4});
        wait_ready();
        count_high(0, 16, c);
        check("steady4_ontime", c, 4);
        wait_cnt(0);
        check("steady4_before_pulse", {31'd0, pwm_out[0]}, 0);
        @(negedge clk);
        check("steady4_pulse_start", {31'd0, pwm_out[0]}, 1);

        // Request at cnt 7 accepted, request at cnt 9 ignored
        wait_cnt(7);
        pulse_cfg(6'b00_00_01, {4'd0, 4'd0, 4'd9});
        check("busy_after_accept", {31'd0, cfg_ready}, 0);
        @(negedge clk);
        pulse_cfg(6'b00_00_01, {4'd0, 4'd0, 4'd2});
        wait_cnt(15);
        check("busy_at_tick", {31'd0, cfg_ready}, 0);
        check("tick_at_15", {31'd0, period_tick}, 1);
        @(negedge clk);
        check("ready_after_apply", {31'd0, cfg_ready}, 1);
        count_high(0, 16, c);
        check("first_request_wins", c, 9);

        // Request in the tick cycle waits for the following wrap
        wait_cnt(15);
        pulse_cfg(6'b00_00_01, {4'd0, 4'd0, 4'd12});
        check("tick_accept_pending", {31'd0, cfg_ready}, 0);
        count_high(0, 15, c);
        check("old_duty_kept", c, 9);
        check("tick_accept_still_busy", {31'd0, cfg_ready}, 0);
        @(negedge clk);
        check("tick_accept_applied", {31'd0, cfg_ready}, 1);
        count_high(0, 16, c);
        check("new_duty_12", c, 12);

        // ch1 BLINK duty 15
        pulse_cfg(6'b00_10_00, {4'd0, 4'd15, 4'd0});
        wait_ready();
        count_high(1, 64, c);
        check("blink_ontime_64", c, 30);
        count_high(0, 16, c);
        check("ch0_off", c, 0);

        // ch2 BREATHE duty 15, then duty 8
        pulse_cfg(6'b11_00_00, {4'd15, 4'd0, 4'd0});
        wait_ready();
        count_high(2, 240, c);
        check("breathe15_ontime_240", c, 113);
        pulse_cfg(6'b11_00_00, {4'd8, 4'd0, 4'd0});
        wait_ready();
        mx = 0;
        for (int p = 0; p < 15; p++) begin
            count_high(2, 16, c);
            if (c > mx) mx = c;
        end
        check("breathe8_max_period", mx, 8);

        // Asynchronous reset mid-run
        pulse_cfg(6'b01_10_01, {4'd15, 4'd15, 4'd15});
        wait_ready();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_pwm_out", {29'd0, pwm_out}, 0);
        check("async_rst_cfg_ready", {31'd0, cfg_ready}, 1);
        check("async_rst_tick", {31'd0, period_tick}, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        c = 0;
        repeat (200) begin
            @(negedge clk);
            if (pwm_out != 3'b000) c++;
        end
        check("off_after_reset", c, 0);

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
